// File: rtl/data_mem_resp.sv
// Single-outstanding data-memory responder for the MEM stage: after a fixed latency it
// performs a byte-lane store or an extended load, then holds the response until it is taken.
module data_mem_resp #(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [3:0]  req_we,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_ext,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t        state_reg;
  logic [CW-1:0] cnt_reg;
  logic [31:0]   addr_reg;
  logic [31:0]   wdata_reg;
  logic [3:0]    we_reg;
  logic [2:0]    ext_reg;

  logic [31:0]   mem [DEPTH];
  logic [31:0]   rd_word_reg;

  logic [AW-1:0] acc_idx;
  logic [AW-1:0] rd_idx;
  logic [1:0]    lane;
  logic          is_read;
  logic          is_half;
  logic          is_word;
  logic          acc_err;
  logic          do_access;
  logic          do_write;
  logic [3:0]    be;
  logic [3:0]    mem_be;
  logic [31:0]   wdata_rep;
  logic [7:0]    sel_byte;
  logic [15:0]   sel_half;
  logic [31:0]   load_val;
  logic [31:0]   rdata_next;

  assign acc_idx = addr_reg[AW+1:2];
  assign lane    = addr_reg[1:0];
  // Look up the incoming address while idle so the word is ready even when LATENCY is 1.
  assign rd_idx  = (state_reg == IDLE) ? req_addr[AW+1:2] : acc_idx;

  assign is_read = (we_reg == 4'b0000);
  assign is_half = (we_reg == 4'b0011) ||
                   (is_read && (ext_reg == 3'd3 || ext_reg == 3'd4));
  assign is_word = (we_reg == 4'b1111) ||
                   (is_read && !(ext_reg == 3'd1 || ext_reg == 3'd2 ||
                                 ext_reg == 3'd3 || ext_reg == 3'd4));
  assign acc_err = (is_half && lane[0]) ||
                   (is_word && (lane != 2'd0)) ||
                   (|addr_reg[31:AW+2]);

  assign do_access = (state_reg == BUSY) && (cnt_reg == '0);
  // The reset term discards a store that is still in flight.
  assign do_write  = do_access && !acc_err && !is_read && !rst;
  assign be        = we_reg << lane;

  always_comb begin
    wdata_rep = wdata_reg;
    case (we_reg)
      4'b0001: wdata_rep = {4{wdata_reg[7:0]}};
      4'b0011: wdata_rep = {2{wdata_reg[15:0]}};
      default: wdata_rep = wdata_reg;
    endcase
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane_en
    assign mem_be[gi] = do_write & be[gi];
  end

  // Read-first RAM: the registered word always predates this request's own store.
  always_ff @(posedge clk) begin
    rd_word_reg <= mem[rd_idx];
    for (int i = 0; i < 4; i++) begin
      if (mem_be[i]) mem[acc_idx][8*i +: 8] <= wdata_rep[8*i +: 8];
    end
  end

  assign sel_byte = rd_word_reg[8*lane +: 8];
  assign sel_half = rd_word_reg[16*addr_reg[1] +: 16];

  always_comb begin
    load_val = rd_word_reg;
    case (ext_reg)
      3'd1:    load_val = {{24{sel_byte[7]}}, sel_byte};
      3'd2:    load_val = {24'h0, sel_byte};
      3'd3:    load_val = {{16{sel_half[15]}}, sel_half};
      3'd4:    load_val = {16'h0, sel_half};
      default: load_val = rd_word_reg;
    endcase
    rdata_next = (acc_err || !is_read) ? 32'h0 : load_val;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'h0;
      rsp_err   <= 1'b0;
      cnt_reg   <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (req_valid && req_ready) begin
            addr_reg  <= req_addr;
            we_reg    <= req_we;
            wdata_reg <= req_wdata;
            ext_reg   <= req_ext;
            cnt_reg   <= CW'(LATENCY - 1);
            req_ready <= 1'b0;
            state_reg <= BUSY;
          end
        end
        BUSY: begin
          if (cnt_reg != '0) begin
            cnt_reg <= cnt_reg - 1'b1;
          end else begin
            rsp_valid <= 1'b1;
            rsp_rdata <= rdata_next;
            rsp_err   <= acc_err;
            state_reg <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            state_reg <= IDLE;
          end
        end
        default: begin
          state_reg <= IDLE;
          req_ready <= 1'b1;
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
